// File: rtl/wr_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : wr_sweep_ctrl
// Purpose : Runs one HBM write-benchmark engine repeatedly across a doubling
//           sweep of burst sizes and streams one result record per run.
// Revision: 1.0 - initial release
// ============================================================================
module wr_sweep_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 33,
  parameter int unsigned PARAMS_BITS    = 256,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'hFFFF_FFFF,
  parameter int unsigned RES_WIDTH      = 128
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_work_group_size,
  input  logic [31:0]            cfg_stride,
  input  logic [63:0]            cfg_num_mem_ops,
  input  logic [ADDR_WIDTH-1:0]  cfg_init_addr,
  input  logic [15:0]            cfg_burst_min,
  input  logic [15:0]            cfg_burst_max,
  input  logic [15:0]            cfg_reps,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   eng_start,
  output logic [PARAMS_BITS-1:0] eng_params,
  input  logic                   eng_end_of_exec,
  input  logic [63:0]            eng_lat_timer_sum,
  output logic                   res_valid,
  output logic [RES_WIDTH-1:0]   res_data,
  input  logic                   res_ready
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_START  = 3'd2,
    S_RUN    = 3'd3,
    S_REPORT = 3'd4,
    S_NEXT   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            wgs_q, stride_q;
  logic [63:0]            nmo_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [15:0]            bmax_q, reps_q, burst_q, rep_q;
  logic                   setup_cnt_q;
  logic [31:0]            wd_q;
  logic                   timeout_q;
  logic                   busy_q, done_q, err_q;
  logic [PARAMS_BITS-1:0] params_q;
  logic [RES_WIDTH-1:0]   res_q;

  logic                   w_cfg_bad, w_wd_expired, w_more_reps, w_last_burst;
  logic [15:0]            w_reps_eff;
  logic [PARAMS_BITS-1:0] w_params;
  logic [RES_WIDTH-1:0]   w_res;

  // A sweep with no valid first burst runs nothing and flags an error.
  assign w_cfg_bad    = (cfg_burst_min == 16'd0) || (cfg_burst_min > cfg_burst_max);
  // Expires after TIMEOUT_CYCLES cycles spent in RUN.
  assign w_wd_expired = ({1'b0, wd_q} + 33'd1) >= {1'b0, TIMEOUT_CYCLES};
  assign w_reps_eff   = (reps_q == 16'd0) ? 16'd1 : reps_q;
  assign w_more_reps  = ({1'b0, rep_q} + 17'd1) < {1'b0, w_reps_eff};
  // Doubling from bit 15 would overflow, so that burst is always the last.
  assign w_last_burst = burst_q[15] || ({burst_q, 1'b0} > {1'b0, bmax_q});

  // Pack the engine parameter word from the latched config and current burst.
  always_comb begin
    w_params                     = '0;
    w_params[31:0]               = wgs_q;
    w_params[63:32]              = stride_q;
    w_params[127:64]             = nmo_q;
    w_params[159:128]            = {16'd0, burst_q};
    w_params[ADDR_WIDTH+159:160] = addr_q;
  end

  // Build the result record for the run that is leaving RUN this cycle.
  always_comb begin
    w_res         = '0;
    w_res[63:0]   = eng_end_of_exec ? eng_lat_timer_sum : 64'hFFFF_FFFF_FFFF_FFFF;
    w_res[79:64]  = burst_q;
    w_res[95:80]  = rep_q;
    w_res[96]     = ~eng_end_of_exec;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; completion takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (cfg_start) state_d = w_cfg_bad ? S_FINISH : S_SETUP;
      S_SETUP:  if (setup_cnt_q) state_d = S_START;
      S_START:  state_d = S_RUN;
      S_RUN:    if (eng_end_of_exec || w_wd_expired) state_d = S_REPORT;
      S_REPORT: if (res_ready) state_d = timeout_q ? S_FINISH : S_NEXT;
      S_NEXT:   state_d = (w_more_reps || !w_last_burst) ? S_SETUP : S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Config latch, sweep counters, watchdog and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wgs_q       <= '0;
      stride_q    <= '0;
      nmo_q       <= '0;
      addr_q      <= '0;
      bmax_q      <= '0;
      reps_q      <= '0;
      burst_q     <= '0;
      rep_q       <= '0;
      setup_cnt_q <= 1'b0;
      wd_q        <= '0;
      timeout_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      params_q    <= '0;
      res_q       <= '0;
    end else begin
      done_q <= (state_q == S_FINISH);
      case (state_q)
        S_IDLE: begin
          if (cfg_start) begin
            wgs_q       <= cfg_work_group_size;
            stride_q    <= cfg_stride;
            nmo_q       <= cfg_num_mem_ops;
            addr_q      <= cfg_init_addr;
            bmax_q      <= cfg_burst_max;
            reps_q      <= cfg_reps;
            burst_q     <= cfg_burst_min;
            rep_q       <= 16'd0;
            setup_cnt_q <= 1'b0;
            err_q       <= w_cfg_bad;
            busy_q      <= 1'b1;
          end
        end
        S_SETUP: begin
          params_q    <= w_params;
          setup_cnt_q <= ~setup_cnt_q;
        end
        S_START: wd_q <= '0;
        S_RUN: begin
          wd_q <= wd_q + 32'd1;
          if (eng_end_of_exec || w_wd_expired) begin
            res_q     <= w_res;
            timeout_q <= ~eng_end_of_exec;
            if (!eng_end_of_exec) err_q <= 1'b1;
          end
        end
        S_NEXT: begin
          if (w_more_reps) begin
            rep_q <= rep_q + 16'd1;
          end else begin
            rep_q <= 16'd0;
            if (!w_last_burst) burst_q <= {burst_q[14:0], 1'b0};
          end
        end
        S_FINISH: busy_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign eng_start  = (state_q == S_START);
  assign eng_params = params_q;
  assign res_valid  = (state_q == S_REPORT);
  assign res_data   = res_q;

endmodule
`default_nettype wire

// File: tb/tb_wr_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_wr_sweep_ctrl
// Purpose : Directed self-checking bench for wr_sweep_ctrl.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_wr_sweep_ctrl;
  localparam int          AW      = 33;
  localparam int          PB      = 256;
  localparam int          RW      = 128;
  localparam logic [31:0] TO      = 32'd150;
  localparam int          ENG_LAT = 100;
  localparam logic [63:0] TBASE   = 64'h0000_1000_0000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic [31:0]   cfg_work_group_size, cfg_stride;
  logic [63:0]   cfg_num_mem_ops;
  logic [AW-1:0] cfg_init_addr;
  logic [15:0]   cfg_burst_min, cfg_burst_max, cfg_reps;
  logic          busy, done, err, eng_start;
  logic [PB-1:0] eng_params;
  logic          eng_end_of_exec;
  logic [63:0]   eng_lat_timer_sum;
  logic          res_valid;
  logic [RW-1:0] res_data;
  logic          res_ready;

  wr_sweep_ctrl #(
    .ADDR_WIDTH(AW), .PARAMS_BITS(PB), .TIMEOUT_CYCLES(TO), .RES_WIDTH(RW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start),
    .cfg_work_group_size(cfg_work_group_size), .cfg_stride(cfg_stride),
    .cfg_num_mem_ops(cfg_num_mem_ops), .cfg_init_addr(cfg_init_addr),
    .cfg_burst_min(cfg_burst_min), .cfg_burst_max(cfg_burst_max), .cfg_reps(cfg_reps),
    .busy(busy), .done(done), .err(err), .eng_start(eng_start), .eng_params(eng_params),
    .eng_end_of_exec(eng_end_of_exec), .eng_lat_timer_sum(eng_lat_timer_sum),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Scenario knobs and observations from run_sweep.
  int stall_n = 0;
  bit eng_never = 1'b0;
  int repulse_at = -1;
  int start_cyc[$];
  logic [PB-1:0] start_par[$];
  logic [RW-1:0] recs[$];
  int rec_cyc[$];
  int vfirst[$];
  int eoe_cyc[$];
  int done_cnt, done_cyc, stall_bad, start_wide;

  // Runs one sweep (cfg_start already driven) acting as engine and result sink.
  task automatic run_sweep(input int budget);
    int cyc, post, eng_cnt, stall_left;
    bit prev_start, prev_valid;
    logic [RW-1:0] held;
    start_cyc.delete(); start_par.delete(); recs.delete();
    rec_cyc.delete(); vfirst.delete(); eoe_cyc.delete();
    cyc = 0; post = -1; eng_cnt = 0; stall_left = stall_n;
    prev_start = 1'b0; prev_valid = 1'b0; held = '0;
    done_cnt = 0; done_cyc = -1; stall_bad = 0; start_wide = 0;
    while (cyc < budget && post != 0) begin
      @(posedge clk); #1; cyc++;
      cfg_start = 1'b0;
      if (cyc == repulse_at) begin
        cfg_start = 1'b1;
        cfg_burst_min = 16'd0;
      end
      eng_end_of_exec = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_end_of_exec = 1'b1;
          eng_lat_timer_sum = TBASE + 64'(start_cyc.size());
          eoe_cyc.push_back(cyc);
        end
      end
      if (eng_start) begin
        start_cyc.push_back(cyc);
        start_par.push_back(eng_params);
        if (!eng_never) eng_cnt = ENG_LAT;
        if (prev_start) start_wide++;
      end
      prev_start = eng_start;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (post < 0) post = 3;
      end else if (post > 0) begin
        post--;
      end
      res_ready = 1'b0;
      if (res_valid) begin
        if (!prev_valid) begin
          vfirst.push_back(cyc);
          held = res_data;
        end else if (res_data !== held) begin
          stall_bad++;
        end
        if (stall_left > 0) stall_left--;
        else begin
          res_ready = 1'b1;
          recs.push_back(res_data);
          rec_cyc.push_back(cyc);
        end
      end
      prev_valid = res_valid && !res_ready;
    end
  endtask

  task automatic set_cfg(input logic [15:0] bmin, input logic [15:0] bmax, input logic [15:0] reps);
    cfg_work_group_size = 32'h0001_0000;
    cfg_stride          = 32'h0000_0040;
    cfg_num_mem_ops     = 64'h0000_0002_0000_03E8;
    cfg_init_addr       = 33'h1_2345_6780;
    cfg_burst_min = bmin;
    cfg_burst_max = bmax;
    cfg_reps      = reps;
    stall_n = 0; eng_never = 1'b0; repulse_at = -1;
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({busy, done, err, eng_start, res_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, done, err, eng_start, res_valid});
    end
    n_cmp++;
    if (eng_params !== '0) begin n_fail++; $display("FAIL reset_params: got %h want 0", eng_params); end
    n_cmp++;
    if (res_data !== '0) begin n_fail++; $display("FAIL reset_res_data: got %h want 0", res_data); end
  endtask

  task automatic test_sweep;
    logic [15:0] b;
    logic [RW-1:0] exp;
    set_cfg(16'd32, 16'd512, 16'd1);
    cfg_start = 1'b1;
    run_sweep(2000);
    n_cmp++;
    if (recs.size() != 5) begin n_fail++; $display("FAIL sweep_count: got %0d want 5", recs.size()); end
    for (int i = 0; i < 5 && i < recs.size(); i++) begin
      b = 16'd32 << i;
      exp = {31'd0, 1'b0, 16'd0, b, TBASE + 64'(i + 1)};
      n_cmp++;
      if (recs[i] !== exp) begin n_fail++; $display("FAIL sweep_rec%0d: got %h want %h", i, recs[i], exp); end
    end
    n_cmp++;
    if (done_cnt != 1 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL sweep_end: got done_cnt=%0d err=%b busy=%b want 1 0 0", done_cnt, err, busy);
    end
    if (start_cyc.size() >= 2 && rec_cyc.size() >= 1 && eoe_cyc.size() >= 1 && vfirst.size() >= 1) begin
      n_cmp++;
      if (start_cyc[0] != 3) begin n_fail++; $display("FAIL cfg_to_start: got %0d want 3", start_cyc[0]); end
      n_cmp++;
      if (vfirst[0] != eoe_cyc[0] + 1) begin
        n_fail++; $display("FAIL eoe_to_valid: got %0d want %0d", vfirst[0], eoe_cyc[0] + 1);
      end
      n_cmp++;
      if (start_cyc[1] != rec_cyc[0] + 4) begin
        n_fail++; $display("FAIL hs_to_start: got %0d want %0d", start_cyc[1], rec_cyc[0] + 4);
      end
    end else begin
      n_cmp++; n_fail++; $display("FAIL sweep_timing: got too few events want >=2 starts");
    end
  endtask

  task automatic test_bad_cfg;
    for (int k = 0; k < 2; k++) begin
      if (k == 0) set_cfg(16'd0, 16'd512, 16'd1);
      else        set_cfg(16'd256, 16'd128, 16'd1);
      cfg_start = 1'b1;
      run_sweep(50);
      n_cmp++;
      if (start_cyc.size() != 0 || recs.size() != 0) begin
        n_fail++; $display("FAIL bad_cfg%0d_runs: got starts=%0d recs=%0d want 0 0", k, start_cyc.size(), recs.size());
      end
      n_cmp++;
      if (done_cyc != 2) begin n_fail++; $display("FAIL bad_cfg%0d_done: got cycle %0d want 2", k, done_cyc); end
      n_cmp++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL bad_cfg%0d_err: got %b want 1", k, err); end
    end
  endtask

  task automatic test_reps;
    logic [PB-1:0] ep;
    logic [RW-1:0] exp;
    set_cfg(16'd64, 16'd64, 16'd3);
    cfg_start = 1'b1;
    ep = '0;
    ep[31:0]        = cfg_work_group_size;
    ep[63:32]       = cfg_stride;
    ep[127:64]      = cfg_num_mem_ops;
    ep[159:128]     = 32'd64;
    ep[AW+159:160]  = cfg_init_addr;
    run_sweep(1000);
    n_cmp++;
    if (recs.size() != 3 || start_cyc.size() != 3) begin
      n_fail++; $display("FAIL reps_count: got recs=%0d starts=%0d want 3 3", recs.size(), start_cyc.size());
    end
    for (int i = 0; i < 3 && i < recs.size() && i < start_par.size(); i++) begin
      exp = {31'd0, 1'b0, 16'(i), 16'd64, TBASE + 64'(i + 1)};
      n_cmp++;
      if (recs[i] !== exp) begin n_fail++; $display("FAIL reps_rec%0d: got %h want %h", i, recs[i], exp); end
      n_cmp++;
      if (start_par[i] !== ep) begin n_fail++; $display("FAIL reps_params%0d: got %h want %h", i, start_par[i], ep); end
    end
    n_cmp++;
    if (start_wide != 0 || err !== 1'b0 || done_cnt != 1) begin
      n_fail++; $display("FAIL reps_misc: got wide=%0d err=%b done=%0d want 0 0 1", start_wide, err, done_cnt);
    end
  endtask

  task automatic test_timeout;
    logic [RW-1:0] exp;
    set_cfg(16'd128, 16'd1024, 16'd2);
    eng_never = 1'b1;
    cfg_start = 1'b1;
    run_sweep(600);
    exp = {31'd0, 1'b1, 16'd0, 16'd128, 64'hFFFF_FFFF_FFFF_FFFF};
    n_cmp++;
    if (recs.size() != 1 || start_cyc.size() != 1) begin
      n_fail++; $display("FAIL to_count: got recs=%0d starts=%0d want 1 1", recs.size(), start_cyc.size());
    end else begin
      n_cmp++;
      if (recs[0] !== exp) begin n_fail++; $display("FAIL to_rec: got %h want %h", recs[0], exp); end
      n_cmp++;
      if (rec_cyc[0] != start_cyc[0] + int'(TO) + 1) begin
        n_fail++; $display("FAIL to_latency: got %0d want %0d", rec_cyc[0], start_cyc[0] + int'(TO) + 1);
      end
      n_cmp++;
      if (done_cyc != rec_cyc[0] + 2) begin
        n_fail++; $display("FAIL to_done: got %0d want %0d", done_cyc, rec_cyc[0] + 2);
      end
    end
    n_cmp++;
    if (err !== 1'b1 || done_cnt != 1) begin
      n_fail++; $display("FAIL to_err: got err=%b done=%0d want 1 1", err, done_cnt);
    end
    eng_never = 1'b0;
  endtask

  task automatic test_stall;
    logic [RW-1:0] exp;
    set_cfg(16'd256, 16'd256, 16'd2);
    stall_n = 20;
    cfg_start = 1'b1;
    run_sweep(1000);
    exp = {31'd0, 1'b0, 16'd0, 16'd256, TBASE + 64'd1};
    n_cmp++;
    if (stall_bad != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad); end
    if (recs.size() == 2 && start_cyc.size() == 2 && vfirst.size() >= 1) begin
      n_cmp++;
      if (rec_cyc[0] != vfirst[0] + 20) begin
        n_fail++; $display("FAIL stall_hold: got %0d want %0d", rec_cyc[0], vfirst[0] + 20);
      end
      n_cmp++;
      if (recs[0] !== exp) begin n_fail++; $display("FAIL stall_rec: got %h want %h", recs[0], exp); end
      n_cmp++;
      if (start_cyc[1] != rec_cyc[0] + 4) begin
        n_fail++; $display("FAIL stall_next_start: got %0d want %0d", start_cyc[1], rec_cyc[0] + 4);
      end
    end else begin
      n_cmp++; n_fail++;
      $display("FAIL stall_count: got recs=%0d starts=%0d want 2 2", recs.size(), start_cyc.size());
    end
  endtask

  task automatic test_reps0_ignore;
    logic [RW-1:0] exp;
    set_cfg(16'd16, 16'd16, 16'd0);
    repulse_at = 50;
    cfg_start = 1'b1;
    run_sweep(600);
    exp = {31'd0, 1'b0, 16'd0, 16'd16, TBASE + 64'd1};
    n_cmp++;
    if (recs.size() != 1 || start_cyc.size() != 1) begin
      n_fail++; $display("FAIL reps0_count: got recs=%0d starts=%0d want 1 1", recs.size(), start_cyc.size());
    end else begin
      n_cmp++;
      if (recs[0] !== exp) begin n_fail++; $display("FAIL reps0_rec: got %h want %h", recs[0], exp); end
    end
    n_cmp++;
    if (err !== 1'b0 || done_cnt != 1) begin
      n_fail++; $display("FAIL ignore_cfg: got err=%b done=%0d want 0 1", err, done_cnt);
    end
    repulse_at = -1;
  endtask

  task automatic test_reset_mid_run;
    int seen;
    set_cfg(16'd32, 16'd64, 16'd1);
    cfg_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    n_cmp++;
    if (busy !== 1'b1 || eng_params === '0) begin
      n_fail++; $display("FAIL midrun_active: got busy=%b params=%h want 1 nonzero", busy, eng_params);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({busy, done, err, eng_start, res_valid} !== 5'b0 || eng_params !== '0 || res_data !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got flags=%b params=%h res=%h want 0", {busy, done, err, eng_start, res_valid}, eng_params, res_data);
    end
    rst_n = 1'b1;
    eng_end_of_exec = 1'b1;
    eng_lat_timer_sum = 64'hDEAD;
    @(posedge clk); #1;
    eng_end_of_exec = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid || eng_start || busy) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL late_eoe: got %0d active cycles want 0", seen); end
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; eng_end_of_exec = 1'b0; eng_lat_timer_sum = '0; res_ready = 1'b0;
    set_cfg(16'd0, 16'd0, 16'd0);
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_sweep;
    test_bad_cfg;
    test_reps;
    test_timeout;
    test_stall;
    test_reps0_ignore;
    test_reset_mid_run;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
